seven_seg_scan: RTL

- Time-multiplexed scan controller for the four-digit seven-segment display.
- Divides the system clock into fixed digit slots and steps a 2-bit digit index through 0..3.
  - The index drives the select input of the downstream 4-to-1 segment-data mux.
  - The block drives the matching active-low anode line.
- An optional blanking interval at the start of each slot suppresses ghosting.

---
 rtl/seven_seg_scan.sv | 85 ++++++++
 1 files changed

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed scan controller for a four-digit
// seven-segment display. Steps a 2-bit digit index through 0..3, one slot of
// DIV clocks per digit, and drives the matching active-low anode.
//
// Build option: define SEVEN_SEG_BLANK_EN to hold all anodes off for the
// first BLANK cycles of every slot (anti-ghosting). Without the macro the
// BLANK parameter has no effect and an enabled digit is lit for its whole slot.
//
// All outputs are registered and computed from the next-state counter/index,
// so sel, an and tick move together on the same edge.
module seven_seg_scan #(
  parameter int unsigned DIV   = 100000,
  parameter int unsigned BLANK = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] digit_en,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       tick
);

  localparam int unsigned   CW      = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

`ifdef SEVEN_SEG_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    an_q, an_d;
  logic          tick_q, tick_d;
  logic          blank_w;

  // State register: synchronous reset wins over everything, including en.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sel_q  <= 2'd0;
      an_q   <= 4'b1111;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      an_q   <= an_d;
      tick_q <= tick_d;
    end
  end

  // Next slot counter / digit index; counter and index freeze while en=0.
  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    tick_d = 1'b0;
    if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        sel_d  = sel_q + 2'd1;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Anode drive from next-state values: lit only for an enabled digit outside
  // the blank window. A masked digit still consumes its slot, keeping the
  // refresh rate constant.
  always_comb begin
    blank_w = BLANK_ON && (32'(cnt_d) < BLANK);
    an_d    = 4'b1111;
    if (en && digit_en[sel_d] && !blank_w) begin
      an_d = ~(4'b0001 << sel_d);
    end
  end

  assign sel  = sel_q;
  assign an   = an_q;
  assign tick = tick_q;

endmodule
